tree_node_resp_collector: RTL and testbench

Response concentrator for one node of the generated module tree. A parent node fans requests out to `NUM_CHILD` child instances; this block is the return path. It gathers one response beat from each child per round, using round-robin arbitration with valid/ready handshakes. Accepted beats are serialised through a one-entry output register to the parent, tagged with the source child index. A pulse marks completion of each round.

---
 rtl/tree_node_resp_collector.sv | 118 +++++++++++
 tb/tb_tree_node_resp_collector.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_node_resp_collector.sv
// ============================================================================
// Module   : tree_node_resp_collector
// Purpose  : Round-robin response concentrator for one tree node. Collects
//            one beat per child per round and forwards the beats to the parent
//            through a one-entry register, tagged with the source child index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tree_node_resp_collector #(
    parameter int NUM_CHILD = 10,
    parameter int DATA_W    = 16,
    parameter int SRC_W     = $clog2(NUM_CHILD)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CHILD-1:0]          child_valid,
    input  logic [NUM_CHILD*DATA_W-1:0]   child_data,
    output logic [NUM_CHILD-1:0]          child_ready,
    output logic                          up_valid,
    input  logic                          up_ready,
    output logic [DATA_W-1:0]             up_data,
    output logic [SRC_W-1:0]              up_src,
    output logic                          round_done,
    output logic [7:0]                    round_cnt
);

    localparam logic [SRC_W:0]       c_NUM  = (SRC_W+1)'(NUM_CHILD);
    localparam logic [SRC_W-1:0]     c_LAST = SRC_W'(NUM_CHILD - 1);
    localparam logic [NUM_CHILD-1:0] c_ALL  = '1;

    logic [NUM_CHILD-1:0] r_mask;
    logic [SRC_W-1:0]     r_rr_ptr;
    logic                 r_up_valid;
    logic [DATA_W-1:0]    r_up_data;
    logic [SRC_W-1:0]     r_up_src;
    logic                 r_round_done;
    logic [7:0]           r_round_cnt;

    logic [NUM_CHILD-1:0] w_elig;
    logic                 w_found;
    logic [SRC_W-1:0]     w_gidx;
    logic [SRC_W:0]       w_sum;
    logic                 w_slot_free;
    logic                 w_accept;
    logic [NUM_CHILD-1:0] w_grant_oh;
    logic [NUM_CHILD-1:0] w_mask_set;
    logic                 w_complete;
    logic [SRC_W-1:0]     w_rr_next;
    logic [DATA_W-1:0]    w_sel_data;

    assign w_elig = child_valid & ~r_mask;

    // Search upward from the round-robin pointer; the sum stays below
    // 2*NUM_CHILD so a single conditional subtract performs the wrap.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_CHILD; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_sum >= c_NUM) begin
                w_sum = w_sum - c_NUM;
            end
            if (!w_found && w_elig[w_sum[SRC_W-1:0]]) begin
                w_found = 1'b1;
                w_gidx  = w_sum[SRC_W-1:0];
            end
        end
    end

    assign w_slot_free = !r_up_valid || up_ready;
    assign w_accept    = w_found && w_slot_free && !rst;
    assign w_grant_oh  = w_accept ? (NUM_CHILD'(1) << w_gidx) : '0;
    assign w_mask_set  = r_mask | w_grant_oh;
    assign w_complete  = w_accept && (w_mask_set == c_ALL);
    assign w_rr_next   = (w_gidx == c_LAST) ? '0 : w_gidx + SRC_W'(1);
    assign w_sel_data  = child_data[w_gidx*DATA_W +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask       <= '0;
            r_rr_ptr     <= '0;
            r_up_valid   <= 1'b0;
            r_up_data    <= '0;
            r_up_src     <= '0;
            r_round_done <= 1'b0;
            r_round_cnt  <= 8'd0;
        end else begin
            r_round_done <= w_complete;
            if (w_accept) begin
                // An accept during a drain simply replaces the held beat.
                r_up_valid <= 1'b1;
                r_up_data  <= w_sel_data;
                r_up_src   <= w_gidx;
                r_rr_ptr   <= w_rr_next;
                if (w_complete) begin
                    r_mask      <= '0;
                    r_round_cnt <= r_round_cnt + 8'd1;
                end else begin
                    r_mask <= w_mask_set;
                end
            end else if (up_ready) begin
                r_up_valid <= 1'b0;
            end
        end
    end

    assign child_ready = w_grant_oh;
    assign up_valid    = r_up_valid;
    assign up_data     = r_up_data;
    assign up_src      = r_up_src;
    assign round_done  = r_round_done;
    assign round_cnt   = r_round_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tree_node_resp_collector.sv
// ============================================================================
// Module   : tb_tree_node_resp_collector
// Purpose  : Scoreboard bench for tree_node_resp_collector (10x16 and 3x8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tree_node_resp_collector;

    localparam int N  = 10;
    localparam int DW = 16;
    localparam int SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    cv;
    logic [N*DW-1:0] cd;
    logic [N-1:0]    cr;
    logic            uv, ur, rd;
    logic [DW-1:0]   ud;
    logic [SW-1:0]   us;
    logic [7:0]      rc;

    logic [2:0]      cv2, cr2;
    logic [23:0]     cd2;
    logic            uv2, ur2, rd2;
    logic [7:0]      ud2;
    logic [1:0]      us2;
    logic [7:0]      rc2;

    tree_node_resp_collector #(.NUM_CHILD(N), .DATA_W(DW)) u_dut (
        .clk(clk), .rst(rst),
        .child_valid(cv), .child_data(cd), .child_ready(cr),
        .up_valid(uv), .up_ready(ur), .up_data(ud), .up_src(us),
        .round_done(rd), .round_cnt(rc)
    );

    tree_node_resp_collector #(.NUM_CHILD(3), .DATA_W(8)) u_dut3 (
        .clk(clk), .rst(rst),
        .child_valid(cv2), .child_data(cd2), .child_ready(cr2),
        .up_valid(uv2), .up_ready(ur2), .up_data(ud2), .up_src(us2),
        .round_done(rd2), .round_cnt(rc2)
    );

    typedef struct packed {
        logic [3:0]  src;
        logic [15:0] data;
        logic        done;
        logic [7:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb2[$];
    logic [15:0] cq[N][$];
    int          n_chk   = 0;
    int          n_fail  = 0;
    int          pulses2 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int s, input logic [15:0] d, input bit dn, input int c);
        exp_t e;
        e.src  = 4'(s);
        e.data = d;
        e.done = dn;
        e.cnt  = 8'(c);
        sb.push_back(e);
    endtask

    function automatic bit anyq();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) r = 1'b1;
        return r;
    endfunction

    // Child models: record accepts mid-cycle, then present the next queued beat.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = cv & cr;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && cq[i].size() != 0) void'(cq[i].pop_front());
            cv[i] = (cq[i].size() != 0);
            cd[i*DW +: DW] = cv[i] ? cq[i][0] : 16'h0;
        end
    endtask

    task automatic drain(input string nm, input int maxc);
        int c = 0;
        while ((sb.size() != 0 || anyq()) && c < maxc) begin
            step();
            c++;
        end
        if (c >= maxc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, %0d beats still expected", nm, sb.size());
        end
    endtask

    task automatic wait_sb(input string nm, input int maxc);
        int c = 0;
        while (sb.size() != 0 && c < maxc) begin
            step();
            c++;
        end
        if (c >= maxc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout, %0d beats still expected", nm, sb.size());
        end
    endtask

    always @(negedge clk) begin : mon_main
        exp_t e;
        if (!rst && uv && ur) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat: got src %0d data 0x%0h, expected none", us, ud);
            end else begin
                e = sb.pop_front();
                chk("up_src", 32'(us), 32'(e.src));
                chk("up_data", 32'(ud), 32'(e.data));
                chk("round_done", 32'(rd), 32'(e.done));
                chk("round_cnt", 32'(rc), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin : mon_small
        exp_t e;
        if (!rst && rd2) pulses2++;
        if (!rst && uv2 && ur2) begin
            if (sb2.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_beat3: got src %0d data 0x%0h, expected none", us2, ud2);
            end else begin
                e = sb2.pop_front();
                chk("up_src3", 32'(us2), 32'(e.src));
                chk("up_data3", 32'(ud2), 32'(e.data));
                chk("round_done3", 32'(rd2), 32'(e.done));
                chk("round_cnt3", 32'(rc2), 32'(e.cnt));
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc;
        int cyc;
        exp_t e;
        cv  = '1;
        cd  = '0;
        ur  = 1'b0;
        cv2 = '0;
        cd2 = '0;
        ur2 = 1'b0;
        rst = 1'b1;

        // Reset state, with children requesting
        #22;
        chk("rst_up_valid", 32'(uv), 32'd0);
        chk("rst_up_src", 32'(us), 32'd0);
        chk("rst_up_data", 32'(ud), 32'd0);
        chk("rst_round_cnt", 32'(rc), 32'd0);
        chk("rst_round_done", 32'(rd), 32'd0);
        chk("rst_child_ready", 32'(cr), 32'd0);
        cv = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full round, all children valid
        ur = 1'b1;
        for (int i = 0; i < N; i++) begin
            cq[i].push_back(16'h0A00 + 16'(i));
            push(i, 16'h0A00 + 16'(i), i == 9, (i == 9) ? 1 : 0);
        end
        drain("full_round", 40);
        chk("round_cnt_r1", 32'(rc), 32'd1);

        // Repeat beat from child 3 held until 7..9 are served
        for (int i = 0; i < 7; i++) begin
            cq[i].push_back(16'h0B00 + 16'(i));
            push(i, 16'h0B00 + 16'(i), 1'b0, 1);
        end
        cq[3].push_back(16'h0C03);
        wait_sb("repeat_first", 30);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("repeat_stall_ready", 32'(cr), 32'd0);
        end
        for (int i = 7; i < N; i++) begin
            cq[i].push_back(16'h0B00 + 16'(i));
            push(i, 16'h0B00 + 16'(i), i == 9, (i == 9) ? 2 : 1);
        end
        push(3, 16'h0C03, 1'b0, 2);
        drain("repeat_release", 30);

        // Backpressure: mask {3}, pointer at 4
        ur = 1'b0;
        for (int i = 4; i < 8; i++) begin
            cq[i].push_back(16'hD000 + 16'(i));
            push(i, 16'hD000 + 16'(i), 1'b0, 2);
        end
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(uv), 32'd1);
            chk("bp_src", 32'(us), 32'd4);
            chk("bp_data", 32'(ud), 32'hD004);
            chk("bp_ready", 32'(cr), 32'd0);
            step();
        end
        ur = 1'b1;
        drain("bp_release", 30);

        // Finish the round across the wrap, then set the pointer to 8
        for (int i = 8; i < 13; i++) begin
            cq[i % N].push_back(16'hE000 + 16'(i % N));
            push(i % N, 16'hE000 + 16'(i % N), (i % N) == 2, ((i % N) == 2) ? 3 : 2);
        end
        drain("round3_wrap", 30);
        cq[7].push_back(16'hE107);
        push(7, 16'hE107, 1'b0, 3);
        drain("ptr_to_8", 20);

        // Pointer 8, children 2/5/9 valid: expect 9, 2, 5
        cq[2].push_back(16'hF002);
        cq[5].push_back(16'hF005);
        cq[9].push_back(16'hF009);
        push(9, 16'hF009, 1'b0, 3);
        push(2, 16'hF002, 1'b0, 3);
        push(5, 16'hF005, 1'b0, 3);
        drain("rr_wrap", 20);

        // Asynchronous reset mid-round with a beat held
        ur = 1'b0;
        cq[0].push_back(16'h5500);
        cq[1].push_back(16'h5501);
        step();
        step();
        chk("pre_rst_valid", 32'(uv), 32'd1);
        chk("pre_rst_data", 32'(ud), 32'h5500);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_up_valid", 32'(uv), 32'd0);
        chk("arst_up_data", 32'(ud), 32'd0);
        chk("arst_up_src", 32'(us), 32'd0);
        chk("arst_round_cnt", 32'(rc), 32'd0);
        chk("arst_round_done", 32'(rd), 32'd0);
        chk("arst_child_ready", 32'(cr), 32'd0);
        for (int i = 0; i < N; i++) cq[i].delete();
        cv = '0;
        cd = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        ur = 1'b1;
        for (int i = 0; i < N; i++) begin
            cq[i].push_back(16'h6600 + 16'(i));
            push(i, 16'h6600 + 16'(i), i == 9, (i == 9) ? 1 : 0);
        end
        drain("post_rst_round", 40);
        chk("round_cnt_post_rst", 32'(rc), 32'd1);

        // Three-child instance: 256 full rounds, counter wraps
        ur2 = 1'b1;
        cd2 = {8'h32, 8'h31, 8'h30};
        for (int b = 0; b < 768; b++) begin
            e.src  = 4'(b % 3);
            e.data = 16'(8'h30 + 8'(b % 3));
            e.done = ((b % 3) == 2);
            e.cnt  = 8'((b / 3) + (((b % 3) == 2) ? 1 : 0));
            sb2.push_back(e);
        end
        @(posedge clk);
        #1;
        cv2 = 3'b111;
        acc = 0;
        cyc = 0;
        while (acc < 768 && cyc < 3000) begin
            @(negedge clk);
            if (|cr2) acc++;
            cyc++;
        end
        @(posedge clk);
        #1;
        cv2 = '0;
        if (acc < 768) begin
            n_chk++;
            n_fail++;
            $display("FAIL small_accepts: got %0d accepts, expected 768", acc);
        end
        cyc = 0;
        while (sb2.size() != 0 && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        @(posedge clk);
        #1;
        chk("small_queue_empty", 32'(sb2.size()), 32'd0);
        chk("small_round_cnt_wrap", 32'(rc2), 32'd0);
        chk("small_round_pulses", 32'(pulses2), 32'd256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
